// File: rtl/pb_port_fifo_io.sv
// rtl/pb_port_fifo_io.sv - port-bus I/O peripheral with TX/RX byte FIFOs, status and interrupt FSM
module pb_port_fifo_io #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         DEPTH     = 8,
  parameter int         CW        = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} irq_state_t;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0] tx_count, rx_count;
  logic          ie, tx_ovf, rx_ovf;
  irq_state_t    state;

  // Address decode: offset wraps mod 256, so the window test is a single compare.
  logic [7:0] off;
  logic       in_win;
  logic [1:0] reg_sel;
  assign off     = port_id - BASE_ADDR;
  assign in_win  = (off < 8'd4);
  assign reg_sel = off[1:0];

  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  logic wr_data, wr_ctrl, flush, ovf_clr;
  assign wr_data = write_strobe && in_win && (reg_sel == 2'd0);
  assign wr_ctrl = write_strobe && in_win && (reg_sel == 2'd1);
  assign flush   = wr_ctrl && out_port[2];
  assign ovf_clr = wr_ctrl && out_port[1];

  // A push on a full TX FIFO is still accepted when the head leaves the same cycle.
  logic tx_pop, tx_push, tx_drop, rx_push, rx_pop, rx_drop;
  assign tx_pop  = !tx_empty && tx_ready && !flush;
  assign tx_push = wr_data && (!tx_full || tx_pop) && !flush;
  assign tx_drop = wr_data && tx_full && !tx_pop && !flush;
  assign rx_push = rx_valid && !rx_full && !flush;
  assign rx_pop  = read_strobe && in_win && (reg_sel == 2'd0) && !rx_empty && !flush;
  assign rx_drop = rx_valid && rx_full;

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];

  // Register read mux; zero outside the window so several peripherals can be OR-ed.
  always_comb begin
    in_port = 8'h00;
    if (in_win) begin
      case (reg_sel)
        2'd0: if (!rx_empty) in_port = rx_mem[rx_rptr];
        2'd1: in_port = {1'b0, ie, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty};
        2'd2: in_port = {{(8-CW){1'b0}}, rx_count};
        default: in_port = {{(8-CW){1'b0}}, tx_count};
      endcase
    end
  end

  // FIFO storage writes; contents need no reset since outputs are gated by the counts.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= out_port;
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // TX pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Control bits; an overflow in the same cycle as a clear is still recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie     <= 1'b0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= out_port[0];
      if (ovf_clr) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end
      if (tx_drop) tx_ovf <= 1'b1;
      if (rx_drop) rx_ovf <= 1'b1;
    end
  end

  // Interrupt request FSM; interrupt is registered and high only in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ie && !rx_empty) begin
            state     <= S_REQ;
            interrupt <= 1'b1;
          end
        end
        S_REQ: begin
          if (interrupt_ack) begin
            state     <= S_WAIT;
            interrupt <= 1'b0;
          end else if (!ie || rx_empty) begin
            state     <= S_IDLE;
            interrupt <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rx_empty || !ie) state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_port_fifo_io.sv
// tb/tb_pb_port_fifo_io.sv - directed scoreboard bench for pb_port_fifo_io
module tb_pb_port_fifo_io;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  pb_port_fifo_io #(.BASE_ADDR(BASE), .DEPTH(8)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id = addr;
    out_port = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  // Only used while tx_ready is low, so a full FIFO means the byte is dropped.
  task automatic tx_wr(input logic [7:0] data);
    if (tx_q.size() < 8) tx_q.push_back(data);
    wr(BASE, data);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] want, input string tag);
    port_id = addr;
    read_strobe = 1'b1;
    #1;
    chk(tag, in_port, want);
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic rx_pop_chk(input string tag);
    logic [7:0] want;
    want = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    rd(BASE, want, tag);
  endtask

  task automatic rx_send(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
      rx_q.push_back(d);
    end else begin
      chk("rx_send_timeout", {7'd0, rx_ready}, 8'd1);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] want;

    // reset state
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rx_ready", {7'd0, rx_ready}, 8'd1);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    chk("rst_interrupt", {7'd0, interrupt}, 8'd0);
    chk("rst_tx_data", tx_data, 8'h00);
    rd(BASE + 8'd1, 8'h05, "rst_status");
    rd(BASE + 8'd2, 8'h00, "rst_rx_count");
    rd(BASE + 8'd3, 8'h00, "rst_tx_count");
    tx_wr(8'h11);
    tx_wr(8'h12);
    tx_wr(8'h13);
    rd(BASE + 8'd3, 8'(tx_q.size()), "tx_count_3");
    reset = 1'b1;
    step();
    reset = 1'b0;
    tx_q.delete();
    rd(BASE + 8'd3, 8'(tx_q.size()), "tx_count_after_reset");
    #1;
    chk("tx_valid_after_reset", {7'd0, tx_valid}, 8'd0);

    // TX fill past full, then drain
    for (int i = 0; i < 9; i++) tx_wr(8'hA0 + 8'(i));
    rd(BASE + 8'd3, 8'(tx_q.size()), "tx_count_full");
    rd(BASE + 8'd1, 8'h29, "status_tx_full_ovf");
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      #1;
      if (tx_valid) begin
        want = tx_q.pop_front();
        chk("tx_data", tx_data, want);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_drain_all", 8'(tx_q.size()), 8'd0);
    #1;
    chk("tx_valid_drained", {7'd0, tx_valid}, 8'd0);
    wr(BASE + 8'd1, 8'h02);
    rd(BASE + 8'd1, 8'h05, "status_ovf_cleared");

    // RX with interrupts
    wr(BASE + 8'd1, 8'h01);
    rx_send(8'h11);
    #1;
    chk("irq_n1", {7'd0, interrupt}, 8'd0);
    rx_send(8'h22);
    #1;
    chk("irq_n2", {7'd0, interrupt}, 8'd1);
    rx_send(8'h33);
    rd(BASE + 8'd2, 8'(rx_q.size()), "rx_count_3");
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    #1;
    chk("irq_after_ack", {7'd0, interrupt}, 8'd0);
    step();
    #1;
    chk("irq_wait_no_rereq", {7'd0, interrupt}, 8'd0);
    rx_pop_chk("rx_pop_11");
    rx_pop_chk("rx_pop_22");
    rx_pop_chk("rx_pop_33");
    step();
    step();
    #1;
    chk("irq_idle_after_drain", {7'd0, interrupt}, 8'd0);
    rx_send(8'h44);
    step();
    #1;
    chk("irq_rearm", {7'd0, interrupt}, 8'd1);
    rx_pop_chk("rx_pop_44");
    step();
    #1;
    chk("irq_drop_on_empty", {7'd0, interrupt}, 8'd0);
    wr(BASE + 8'd1, 8'h00);

    // RX full, overflow, pop with source held
    for (int i = 0; i < 8; i++) rx_send(8'h50 + 8'(i));
    rx_valid = 1'b1;
    rx_data = 8'h99;
    #1;
    chk("rx_ready_full", {7'd0, rx_ready}, 8'd0);
    step();
    rd(BASE + 8'd1, 8'h16, "status_rx_full_ovf");
    rx_pop_chk("rx_pop_when_full");
    #1;
    chk("rx_ready_after_pop", {7'd0, rx_ready}, 8'd1);
    @(negedge clk);
    rx_q.push_back(8'h99);
    rx_valid = 1'b0;
    rd(BASE + 8'd2, 8'(rx_q.size()), "rx_count_refill");
    for (int i = 0; i < 8; i++) rx_pop_chk("rx_drain");
    wr(BASE + 8'd1, 8'h02);
    rd(BASE + 8'd1, 8'h05, "status_after_rx_clear");

    // flush wins over same-cycle TX drain and RX push
    tx_wr(8'hC1);
    tx_wr(8'hC2);
    rx_send(8'hD1);
    port_id = BASE + 8'd1;
    out_port = 8'h04;
    write_strobe = 1'b1;
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hD2;
    #1;
    chk("tx_head_pre_flush", tx_data, tx_q[0]);
    @(negedge clk);
    write_strobe = 1'b0;
    rx_valid = 1'b0;
    tx_q.delete();
    rx_q.delete();
    #1;
    chk("tx_valid_post_flush", {7'd0, tx_valid}, 8'd0);
    chk("tx_data_post_flush", tx_data, 8'h00);
    tx_ready = 1'b0;
    rd(BASE + 8'd2, 8'(rx_q.size()), "rx_count_flushed");
    rd(BASE + 8'd3, 8'(tx_q.size()), "tx_count_flushed");
    rd(BASE + 8'd1, 8'h05, "status_flushed");
    rx_pop_chk("rx_read_empty");
    rd(BASE + 8'd2, 8'h00, "rx_no_underflow");

    // address window at a non-zero base
    rd(8'h3F, 8'h00, "below_window");
    rd(8'h44, 8'h00, "above_window");
    wr(BASE + 8'd2, 8'hFF);
    wr(8'h3F, 8'h77);
    wr(8'h44, 8'h77);
    rd(BASE + 8'd1, 8'h05, "status_after_ignored_writes");
    rd(BASE + 8'd3, 8'h00, "tx_count_after_ignored_writes");
    #1;
    chk("tx_valid_after_ignored_writes", {7'd0, tx_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
